// File: rtl/challenge_pack.sv
// Sparse challenge packer/checker: scans 256 coefficients of c, validates the
// ball-polynomial shape and packs the non-zero terms as index and sign lists.
module challenge_pack #(
    parameter int unsigned t = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [31:0]      c_in [0:255],
    output logic                    busy,
    output logic                    done,
    output logic                    ok,
    output logic                    err_coef,
    output logic                    err_weight,
    output logic [7:0]              bad_index,
    output logic [8:0]              weight,
    output logic [8*t-1:0]          idx_list,
    output logic [t-1:0]            sign_list,
    output logic                    idx_valid,
    output logic [7:0]              idx_data,
    output logic                    idx_sign
);

    localparam int unsigned W_CNT = 9;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FIN} state_t;

    state_t      state;
    logic [7:0]  k;
    // Set when a scan is accepted on the completing edge: the previous results
    // must stay visible during the done cycle, so clearing is folded into the
    // first scan step instead.
    logic        fresh;

    logic signed [31:0] coef;
    logic               is_pos;
    logic               is_neg;
    logic               is_bad;
    logic [W_CNT-1:0]   w_base;
    logic [W_CNT-1:0]   w_next;
    logic [8*t-1:0]     il_next;
    logic [t-1:0]       sl_next;
    logic               ec_next;
    logic [7:0]         bi_next;

    // Classify c_in[k] and compute the updated accumulators for this step.
    always_comb begin
        coef    = c_in[k];
        is_pos  = (coef == 32'sd1);
        is_neg  = (coef == -32'sd1);
        is_bad  = !is_pos && !is_neg && (coef != 32'sd0);
        w_base  = fresh ? '0 : weight;
        il_next = fresh ? '0 : idx_list;
        sl_next = fresh ? '0 : sign_list;
        ec_next = fresh ? 1'b0 : err_coef;
        bi_next = fresh ? 8'd0 : bad_index;
        w_next  = w_base;
        if (is_pos || is_neg) begin
            for (int unsigned n = 0; n < t; n++) begin
                if (w_base == W_CNT'(n)) begin
                    il_next[8*n +: 8] = k;
                    sl_next[n]        = is_neg;
                end
            end
            if (w_base != W_CNT'(256)) begin
                w_next = w_base + W_CNT'(1);
            end
        end
        if (is_bad && !ec_next) begin
            ec_next = 1'b1;
            bi_next = k;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= 8'd0;
            fresh      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ok         <= 1'b0;
            err_coef   <= 1'b0;
            err_weight <= 1'b0;
            bad_index  <= 8'd0;
            weight     <= '0;
            idx_list   <= '0;
            sign_list  <= '0;
            idx_valid  <= 1'b0;
            idx_data   <= 8'd0;
            idx_sign   <= 1'b0;
        end else begin
            done      <= 1'b0;
            idx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_SCAN;
                        busy       <= 1'b1;
                        k          <= 8'd0;
                        fresh      <= 1'b0;
                        ok         <= 1'b0;
                        err_coef   <= 1'b0;
                        err_weight <= 1'b0;
                        bad_index  <= 8'd0;
                        weight     <= '0;
                        idx_list   <= '0;
                        sign_list  <= '0;
                    end
                end
                S_SCAN: begin
                    weight    <= w_next;
                    idx_list  <= il_next;
                    sign_list <= sl_next;
                    err_coef  <= ec_next;
                    bad_index <= bi_next;
                    fresh     <= 1'b0;
                    if (fresh) begin
                        ok         <= 1'b0;
                        err_weight <= 1'b0;
                    end
                    if (is_pos || is_neg) begin
                        idx_valid <= 1'b1;
                        idx_data  <= k;
                        idx_sign  <= is_neg;
                    end
                    k <= k + 8'd1;
                    if (k == 8'd255) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    done       <= 1'b1;
                    err_weight <= (weight != W_CNT'(t));
                    ok         <= !err_coef && (weight == W_CNT'(t));
                    if (start) begin
                        state <= S_SCAN;
                        k     <= 8'd0;
                        fresh <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_challenge_pack.sv
// Bench for challenge_pack: table of challenge patterns with expected verdicts,
// a strobe scoreboard, and hand sequences for reset and back-to-back scans.
module tb_challenge_pack;

    localparam int unsigned T = 60;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] c_in [0:255];
    logic               busy, done, ok, err_coef, err_weight;
    logic [7:0]         bad_index;
    logic [8:0]         weight;
    logic [8*T-1:0]     idx_list;
    logic [T-1:0]       sign_list;
    logic               idx_valid;
    logic [7:0]         idx_data;
    logic               idx_sign;

    always #5 clk = ~clk;

    challenge_pack #(.t(T)) dut (
        .clk(clk), .rst(rst), .start(start), .c_in(c_in),
        .busy(busy), .done(done), .ok(ok), .err_coef(err_coef),
        .err_weight(err_weight), .bad_index(bad_index), .weight(weight),
        .idx_list(idx_list), .sign_list(sign_list), .idx_valid(idx_valid),
        .idx_data(idx_data), .idx_sign(idx_sign)
    );

    typedef struct {
        int       kind;
        bit       exp_ok;
        bit       exp_ec;
        bit       exp_ew;
        bit [7:0] exp_bi;
        bit [8:0] exp_w;
        bit       pulse50;
    } vec_t;

    typedef struct {
        logic [7:0] idx;
        logic       sgn;
    } term_t;

    vec_t  vecs [8];
    term_t sbq [$];
    int    total = 0;
    int    bad = 0;
    logic [8*T-1:0] m_il;
    logic [T-1:0]   m_sl;
    logic [8:0]     m_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [8*T-1:0] act, input logic [8*T-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any strobe seen there.
    task automatic tick();
        term_t e;
        @(negedge clk);
        if (idx_valid === 1'b1) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL strobe: unexpected idx %0d sign %0d", idx_data, idx_sign);
            end else begin
                e = sbq.pop_front();
                if (idx_data !== e.idx || idx_sign !== e.sgn) begin
                    bad++;
                    $display("FAIL strobe: got idx %0d sign %0d want idx %0d sign %0d",
                             idx_data, idx_sign, e.idx, e.sgn);
                end
            end
        end
    endtask

    task automatic fill(input int kind);
        bit used [256];
        int cnt;
        int p;
        for (int i = 0; i < 256; i++) begin
            c_in[i] = 32'sd0;
            used[i] = 1'b0;
        end
        case (kind)
            0, 2: for (int i = 196; i < 256; i++) c_in[i] = ((i - 196) % 2 == 1) ? -32'sd1 : 32'sd1;
            3:    for (int i = 0; i <= 60; i++) c_in[i] = (i % 2 == 1) ? -32'sd1 : 32'sd1;
            7:    for (int i = 0; i < 59; i++) c_in[i] = (i % 3 == 0) ? -32'sd1 : 32'sd1;
            5, 6: for (int j = 0; j < 60; j++) c_in[2*j] = (j % 2 == 1) ? -32'sd1 : 32'sd1;
            4: begin
                cnt = 0;
                while (cnt < 60) begin
                    p = int'($urandom_range(0, 255));
                    if (!used[p]) begin
                        used[p] = 1'b1;
                        c_in[p] = ($urandom_range(0, 1) == 1) ? -32'sd1 : 32'sd1;
                        cnt++;
                    end
                end
            end
            default: ;
        endcase
        if (kind == 2) begin
            c_in[10] = 32'sd2;
            c_in[40] = -32'sd5;
        end
        if (kind == 6) begin
            c_in[150] = 32'sh7fff_ffff;
            c_in[151] = -32'sd2;
            c_in[200] = 32'sh8000_0001;
        end
    endtask

    // Reference packing of the current c_in; also queues the expected strobes.
    task automatic model();
        int wi;
        m_il = '0;
        m_sl = '0;
        wi = 0;
        for (int i = 0; i < 256; i++) begin
            if (c_in[i] == 32'sd1 || c_in[i] == -32'sd1) begin
                if (wi < int'(T)) begin
                    m_il[8*wi +: 8] = 8'(i);
                    m_sl[wi]        = (c_in[i] == -32'sd1);
                end
                sbq.push_back('{8'(i), c_in[i] == -32'sd1});
                wi++;
            end
        end
        m_w = 9'(wi);
    endtask

    task automatic check_results(input string tag, input vec_t v);
        check({tag, "_ok"}, 64'(ok), 64'(v.exp_ok));
        check({tag, "_err_coef"}, 64'(err_coef), 64'(v.exp_ec));
        check({tag, "_err_weight"}, 64'(err_weight), 64'(v.exp_ew));
        check({tag, "_bad_index"}, 64'(bad_index), 64'(v.exp_bi));
        check({tag, "_weight"}, 64'(weight), 64'(v.exp_w));
        check({tag, "_weight_model"}, 64'(weight), 64'(m_w));
        check_wide({tag, "_idx_list"}, idx_list, m_il);
        check({tag, "_sign_list"}, 64'(sign_list), 64'(m_sl));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int got;
        fill(v.kind);
        model();
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        got = 0;
        for (int n = 1; n <= 300; n++) begin
            if (v.pulse50 && n == 50) start = 1'b1;
            if (v.pulse50 && n == 51) start = 1'b0;
            tick();
            if (n == 256) check({tag, "_busy_e256"}, 64'(busy), 64'd1);
            if (done === 1'b1) begin
                got = n;
                break;
            end
        end
        check({tag, "_done_latency"}, 64'(got), 64'd257);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        check_results(tag, v);
        check({tag, "_strobes_left"}, 64'(sbq.size()), 64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        sbq.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ok"}, 64'(ok), 64'd0);
        check({tag, "_err"}, 64'({err_coef, err_weight}), 64'd0);
        check({tag, "_bad_index"}, 64'(bad_index), 64'd0);
        check({tag, "_weight"}, 64'(weight), 64'd0);
        check_wide({tag, "_idx_list"}, idx_list, '0);
        check({tag, "_sign_list"}, 64'(sign_list), 64'd0);
        check({tag, "_strobe"}, 64'({idx_valid, idx_data, idx_sign}), 64'd0);
    endtask

    initial begin
        int d1, d2;
        logic [T-1:0] alt_sign;
        vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 8'd0,   9'd60, 1'b0};
        vecs[1] = '{1, 1'b0, 1'b0, 1'b1, 8'd0,   9'd0,  1'b0};
        vecs[2] = '{2, 1'b0, 1'b1, 1'b0, 8'd10,  9'd60, 1'b0};
        vecs[3] = '{3, 1'b0, 1'b0, 1'b1, 8'd0,   9'd61, 1'b0};
        vecs[4] = '{4, 1'b1, 1'b0, 1'b0, 8'd0,   9'd60, 1'b1};
        vecs[5] = '{5, 1'b1, 1'b0, 1'b0, 8'd0,   9'd60, 1'b0};
        vecs[6] = '{6, 1'b0, 1'b1, 1'b0, 8'd150, 9'd60, 1'b0};
        vecs[7] = '{7, 1'b0, 1'b0, 1'b1, 8'd0,   9'd59, 1'b0};
        alt_sign = 60'hAAA_AAAA_AAAA_AAAA;

        rst = 1'b1;
        start = 1'b0;
        fill(1);
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].kind == 0) check("vec0_sign_const", 64'(sign_list), 64'(alt_sign));
        end

        // Reset in the middle of a scan, then restart right after release.
        fill(5);
        model();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        check_zero("midrst");
        sbq.delete();
        rst = 1'b0;
        repeat (5) tick();
        check("midrst_idle_strobes", 64'(idx_valid), 64'd0);
        run_vec(vecs[5], "after_rst");

        // Start held high: scans chain on the completing edge.
        fill(0);
        model();
        model();
        start = 1'b1;
        tick();
        d1 = 0;
        d2 = 0;
        for (int n = 1; n <= 600; n++) begin
            tick();
            if (done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = n;
                    check("hold_first_ok", 64'(ok), 64'd1);
                    check("hold_first_weight", 64'(weight), 64'd60);
                    check("hold_busy_chain", 64'(busy), 64'd1);
                end else begin
                    d2 = n;
                    break;
                end
            end
        end
        check("hold_done1", 64'(d1), 64'd257);
        check("hold_done2", 64'(d2), 64'd514);
        check("hold_second_ok", 64'(ok), 64'd1);
        check_wide("hold_second_idx_list", idx_list, m_il);
        check("hold_second_sign", 64'(sign_list), 64'(alt_sign));
        check("hold_strobes_left", 64'(sbq.size()), 64'd0);
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
